// File: rtl/serial_cla_adder.sv
// Multi-cycle adder that walks the operands LSB-first, one 2-bit CLA slice per clock.
// Latency NSLICE+1 cycles from start to done; start is ignored while RUN.
module serial_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             last_slice;
  logic [1:0]       ak, bk, s;
  logic             c1, g_out, p_out, carry_next;
  logic [WIDTH-1:0] partial_next;

  assign accept     = start && (state_q != S_RUN);
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // One 2-bit CLA slice on the current index
  always_comb begin
    ak         = a_q[{idx_q, 1'b0} +: 2];
    bk         = b_q[{idx_q, 1'b0} +: 2];
    c1         = (ak[0] & bk[0]) | ((ak[0] ^ bk[0]) & carry_q);
    s          = {ak[1] ^ bk[1] ^ c1, ak[0] ^ bk[0] ^ carry_q};
    g_out      = (ak[1] & bk[1]) | ((ak[1] ^ bk[1]) & ak[0] & bk[0]);
    p_out      = (ak[1] ^ bk[1]) & (ak[0] ^ bk[0]);
    carry_next = g_out | (p_out & carry_q);
    partial_next                    = partial_q;
    partial_next[{idx_q, 1'b0} +: 2] = s;
  end

  always_comb begin
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    partial_d  = partial_q;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      partial_d = partial_next;
      carry_d   = carry_next;
      idx_d     = last_slice ? '0 : idx_q + 1'b1;
      if (last_slice) begin
        sum_d      = partial_next;
        c_out_d    = carry_next;
        overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (partial_next[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      partial_q  <= '0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      partial_q  <= partial_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_cla_adder.sv
// Scoreboard bench for serial_cla_adder at WIDTH=16 and WIDTH=2 against an arithmetic model.
module tb_serial_cla_adder;
  localparam int W  = 16;
  localparam int NS = W / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start, c_in, busy, done, c_out, overflow;
  logic [W-1:0]  a, b, sum;
  logic          start2, c_in2, busy2, done2, c_out2, ovf2;
  logic [1:0]    a2, b2, sum2;

  serial_cla_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow));

  serial_cla_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(c_out2), .overflow(ovf2));

  typedef struct {logic [W-1:0] s; logic c; logic v;} exp_t;
  typedef struct {logic [1:0] s; logic c; logic v;} exp2_t;
  exp_t  q[$];
  exp2_t q2[$];

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, last_done_cyc = 0, prev_done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t m;
    int unsigned full;
    full = int'(x) + int'(y) + int'(ci);
    m.s = full[W-1:0];
    m.c = full[W];
    m.v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return m;
  endfunction

  function automatic exp2_t model2(input logic [1:0] x, input logic [1:0] y, input logic ci);
    exp2_t m;
    int unsigned full;
    full = int'(x) + int'(y) + int'(ci);
    m.s = full[1:0];
    m.c = full[2];
    m.v = (x[1] == y[1]) && (full[1] != x[1]);
    return m;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the WIDTH=16 instance: results on done, outputs held otherwise
  initial begin
    exp_t e;
    logic [W+1:0] held;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no result pending");
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("overflow", 32'(overflow), 32'(e.v));
        end
        chk("busy_in_done", 32'(busy), 32'(0));
        held = {sum, c_out, overflow};
        done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
      end else begin
        chk("outputs_held", 32'({sum, c_out, overflow}), 32'(held));
      end
    end
  end

  // Monitor for the WIDTH=2 instance
  initial begin
    exp2_t e;
    forever begin
      @(negedge clk);
      if (!rst && done2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done2: got done2=1 expected no result pending");
        end else begin
          e = q2.pop_front();
          chk("sum2", 32'(sum2), 32'(e.s));
          chk("c_out2", 32'(c_out2), 32'(e.c));
          chk("overflow2", 32'(ovf2), 32'(e.v));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; c_in = tc;
    @(posedge clk);
    q.push_back(model(ta, tb_v, tc));
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  // Called just after the accepting edge; returns edges until done is seen
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (lat == 0) chk("busy_after_start", 32'(busy), 32'(1));
      if (done) break;
      if (lat >= 40) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected %0d", lat, NS);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat, d0;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    va = '{16'h1234, 16'hFFFF, 16'h7FFF};
    vb = '{16'h0FCD, 16'h0001, 16'h0000};
    vc = '{1'b0, 1'b0, 1'b1};

    start = 0; a = '0; b = '0; c_in = 0;
    start2 = 0; a2 = '0; b2 = '0; c_in2 = 0;
    #12;
    chk("reset_outputs", 32'({busy, done, sum, c_out, overflow}), 32'(0));
    chk("reset_outputs2", 32'({busy2, done2, sum2, c_out2, ovf2}), 32'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(lat);
      chk("latency", 32'(lat), 32'(NS));
    end

    // start during RUN must be ignored
    issue(16'h1111, 16'h2222, 1'b0);
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 16'hABCD; b = 16'h5555;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("sum_ignore_start", 32'(sum), 32'h3333);
    repeat (3) @(posedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'(1));

    // reset mid-RUN aborts the operation
    issue(16'h4321, 16'h1234, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_mid_run", 32'({busy, done, sum, c_out, overflow}), 32'(0));
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    issue(16'h00F0, 16'h0F0F, 1'b0);
    wait_done(lat);
    chk("latency_after_reset", 32'(lat), 32'(NS));

    // start held high across DONE gives back-to-back operation
    @(negedge clk);
    start = 1'b1; a = 16'h8001; b = 16'h8001; c_in = 1'b0;
    @(posedge clk);
    q.push_back(model(16'h8001, 16'h8001, 1'b0));
    #1 a = 16'h0001; b = 16'h0002;
    repeat (NS) @(posedge clk);
    q.push_back(model(16'h0001, 16'h0002, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("sum_back_to_back", 32'(sum), 32'h0003);
    repeat (2) @(posedge clk);
    chk("done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'(NS + 1));

    // Randomized traffic with corner operands and stray starts during RUN
    for (int i = 0; i < 150; i++) begin
      bit noise;
      noise = ($urandom_range(0, 3) == 0);
      issue(pick(), pick(), 1'($urandom));
      if (noise) begin
        repeat ($urandom_range(0, NS - 2)) @(posedge clk);
        #1 start = 1'b1; a = W'($urandom); b = W'($urandom);
        @(posedge clk);
        #1 start = 1'b0;
      end
      wait_done(lat);
      if (!noise) chk("latency_rand", 32'(lat), 32'(NS));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // WIDTH=2: every operand combination, single RUN cycle
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      int n;
      v = 5'(i);
      @(negedge clk);
      start2 = 1'b1; a2 = v[4:3]; b2 = v[2:1]; c_in2 = v[0];
      @(posedge clk);
      q2.push_back(model2(v[4:3], v[2:1], v[0]));
      #1 start2 = 1'b0;
      n = 0;
      @(negedge clk);
      chk("busy2", 32'(busy2), 32'(1));
      while (!done2 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("latency2", 32'(n), 32'(1));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    chk("queue2_drained", 32'(q2.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
